spi_reg_bank: RTL
=================

# spi_reg_bank

SPI (mode 0) slave and configuration register bank that sits directly downstream of the input synchronizer. It consumes the already-synchronized `spi_cs_n`, `spi_clk` and `spi_mosi` levels and detects SCLK edges in the system clock domain. It decodes 16-bit write/read frames and drives a bank of control registers consumed by the ALU datapath. The top register is a read-only status window.

## Interface
- `ADDR_W`, default 3: address width; `NUM_REGS = 2**ADDR_W`.
- `REG_W`, default 8: register and data width; frame data field is `REG_W` bits.
- `clk`  input  1  system clock.
- `rstb`  input  1  asynchronous active-low reset.
- `ena`  input  1  global enable; when low, all state holds and `wr_strobe` is 0.
- `spi_cs_n`  input  1  synchronized chip select, active low.
- `spi_clk`  input  1  synchronized SCLK.
- `spi_mosi`  input  1  synchronized MOSI.
- `spi_miso`  output  1  MISO, registered.
- `status_in`  input  REG_W  value returned when reading address `NUM_REGS-1`.
- `regs_out`  output  NUM_REGS*REG_W  flattened register bank; register *k* occupies bits `[k*REG_W +: REG_W]`.
- `wr_strobe`  output  1  one-cycle pulse on each committed write.
- `wr_addr`  output  ADDR_W  address of the last committed write.

One clock; reset is asynchronous and active-low (`clk`, `rstb`).

## Operation
- Frame format, MSB first: an 8-bit command, then `REG_W` data bits.
  - Command bit 7: 1 = write, 0 = read.
  - Command bits `[ADDR_W-1:0]`: address. Remaining bits are ignored.
- Edge detection: `spi_clk` is registered into `sclk_q`.
  - `rise = spi_clk & ~sclk_q`.
  - `fall = ~spi_clk & sclk_q`.
- MOSI is sampled on `rise`. MISO changes on `fall`.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE → CMD when `spi_cs_n` = 0. The bit counter clears.
  - CMD: shift MOSI on each `rise`. After the 8th bit → DATA.
    - For a read, `shift_out` loads the addressed value on that same cycle and `spi_miso` shows `shift_out` MSB.
  - DATA: shift on `rise`; `shift_out` shifts left on `fall`. After the `REG_W`-th bit → DONE.
    - For a write, the register commits and `wr_strobe` pulses on the same cycle.
  - DONE: further SCLK edges are ignored. → IDLE when `spi_cs_n` = 1.
  - Any state → IDLE when `spi_cs_n` = 1. A partial frame is discarded: no write and no strobe.
- Writes to address `NUM_REGS-1` are ignored: no register change, no strobe.
- Reads of address `NUM_REGS-1` return `status_in`, captured at command completion.
- `spi_miso` is 0 whenever `spi_cs_n` = 1 or the state is not DATA.
- `ena` = 0 freezes the FSM, counters, shift registers and `sclk_q`. Edges occurring while `ena` = 0 are lost.

## Timing
- Reset values:
  - all `regs_out` = 0
  - `spi_miso` = 0
  - `wr_strobe` = 0
  - `wr_addr` = 0
  - state = IDLE
  - `sclk_q` = 0
- Write latency: `regs_out` and `wr_strobe` update on the `clk` edge where the final data `rise` is detected. They are visible one cycle after the synchronized `spi_clk` goes high.
- `wr_strobe` is high for exactly one `clk` cycle per frame.
- Read: the first data bit is valid on `spi_miso` one `clk` after the 8th command `rise`.
- SCLK constraints: high and low phases must each be ≥ 4 `clk` cycles, to cover the 2-stage synchronizer, edge detection and MISO output register.
- Reset asserted mid-frame returns the block to reset values immediately. No partial write occurs.

## Configuration
- `SPI_REG_READBACK_EN`:
  - Defined: read frames drive `spi_miso` as described above.
  - Undefined: `shift_out` and the read mux are not built, and `spi_miso` is tied to 0. Read frames are still parsed and cause no writes.

## Structure
- Package `spi_reg_pkg` holds:
  - the state enum `spi_state_t`
  - `CMD_W = 8`
  - `CMD_RW_BIT = 7`
- Sub-module `spi_edge_detect`: registers `spi_clk` and produces `rise`/`fall`, gated by `ena`. It is reused for CS edge detection if needed.

## Test plan
- Write 0xA5 to address 2 (command 0x82) → `regs_out[2]` = 0xA5 and `wr_addr` = 2, `wr_strobe` pulses once, other registers stay 0.
- Write 0x3C to addr 1, then read addr 1 (command 0x01) → MISO bits = 0x3C MSB first, sampled on SCLK rise. Without `SPI_REG_READBACK_EN`, MISO stays 0.
- CS deasserted after 12 bits of a write to addr 0 → `regs_out[0]` unchanged, no strobe. The next full frame works.
- Read addr 7 with `status_in` = 0x5A → MISO returns 0x5A. Write 0xFF to addr 7 → no strobe, read still returns `status_in`.
- 20 SCLK pulses in one CS window writing 0x11 to addr 3 → single commit of 0x11, extra bits ignored.
- `rstb` low mid-frame after writing 0x77 to addr 4 → all registers 0 and MISO 0. Hold `ena` = 0 during a frame → no state change.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM state type and command-frame constants for spi_reg_bank
package spi_reg_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_t;
    localparam int CMD_W      = 8;
    localparam int CMD_RW_BIT = 7;
endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: registers a synchronized level and flags its rising/falling edges, frozen while ena is low
module spi_edge_detect (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q;
    // previous level; held while disabled so edges during ena=0 are lost
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sig_q <= 1'b0;
        else if (ena) sig_q <= sig_i;
    end
    assign rise_o = ena & sig_i & ~sig_q;
    assign fall_o = ena & ~sig_i & sig_q;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave with write/read register bank; readback built only with SPI_REG_READBACK_EN
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    input  logic [REG_W-1:0]                 status_in,
    output logic [(2**ADDR_W)*REG_W-1:0]     regs_out,
    output logic                             wr_strobe,
    output logic [ADDR_W-1:0]                wr_addr
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int CNT_W    = $clog2((REG_W > CMD_W ? REG_W : CMD_W) + 1);

    spi_state_t                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CMD_W-1:0]               cmd_q, cmd_d;
    logic [REG_W-2:0]               data_q, data_d;
    logic [NUM_REGS-1:0][REG_W-1:0] regs_q, regs_d;
    logic                           strobe_q, strobe_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
    logic                           rise, fall;
    logic [CMD_W-1:0]               cmd_full;
    logic [REG_W-1:0]               data_full;
    logic [ADDR_W-1:0]              wr_idx;
    logic                           last_cmd, last_data, commit;

    spi_edge_detect u_sclk (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .sig_i  (spi_clk),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign cmd_full  = {cmd_q[CMD_W-2:0], spi_mosi};
    assign data_full = {data_q, spi_mosi};
    assign wr_idx    = cmd_q[ADDR_W-1:0];
    assign last_cmd  = state_q == CMD  && rise && cnt_q == CNT_W'(CMD_W - 1);
    assign last_data = state_q == DATA && rise && cnt_q == CNT_W'(REG_W - 1);
    // the top address is the read-only status window, so writes to it are dropped
    assign commit    = last_data && cmd_q[CMD_RW_BIT] && !(&wr_idx);

    // frame parser: next state, bit counter, shift registers and register commit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        regs_d    = regs_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        if (spi_cs_n) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = CMD;
            cnt_d   = '0;
        end else if (state_q == CMD && rise) begin
            cmd_d   = cmd_full;
            cnt_d   = last_cmd ? '0 : cnt_q + 1'b1;
            state_d = last_cmd ? DATA : CMD;
        end else if (state_q == DATA && rise) begin
            data_d  = data_full[REG_W-2:0];
            cnt_d   = cnt_q + 1'b1;
            state_d = last_data ? DONE : DATA;
            if (commit) begin
                regs_d[wr_idx] = data_full;
                strobe_d       = 1'b1;
                wr_addr_d      = wr_idx;
            end
        end
    end

    // state register; everything freezes while ena is low
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            regs_q    <= '0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            regs_q    <= regs_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign regs_out  = regs_q;
    assign wr_strobe = strobe_q & ena;
    assign wr_addr   = wr_addr_q;

`ifdef SPI_REG_READBACK_EN
    logic [REG_W-1:0] shift_q, shift_d, rd_val;
    logic             miso_q, miso_d;

    assign rd_val = &cmd_full[ADDR_W-1:0] ? status_in : regs_q[cmd_full[ADDR_W-1:0]];

    // readback shifter: load at command end, hold the MSB through the first data rise, then shift on each fall
    always_comb begin
        shift_d = last_cmd ? (cmd_full[CMD_RW_BIT] ? '0 : rd_val)
                : (state_q == DATA && fall && cnt_q != '0) ? {shift_q[REG_W-2:0], 1'b0}
                : shift_q;
        miso_d  = state_d == DATA && shift_d[REG_W-1];
    end

    // registered MISO output
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shift_q <= '0;
            miso_q  <= 1'b0;
        end else if (ena) begin
            shift_q <= shift_d;
            miso_q  <= miso_d;
        end
    end

    assign spi_miso = miso_q;
`else
    logic unused_readback;
    assign unused_readback = ^{status_in, fall};
    assign spi_miso        = 1'b0;
`endif
endmodule
